// File: rtl/sram_req_arbiter.sv
// Two-into-one sram-like request arbiter: data requester has fixed priority over instruction fetch.
// One registered request toward memory; an in-order tag FIFO routes each data_ok back to its owner.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic             hold_valid_reg;
  logic             hold_src_reg;
  logic             hold_wr_reg;
  logic [1:0]       hold_size_reg;
  logic [3:0]       hold_wstrb_reg;
  logic [31:0]      hold_addr_reg;
  logic [31:0]      hold_wdata_reg;

  logic             tag_mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;

  logic resp_valid;
  logic count_free;
  logic can_accept;
  logic accept;
  logic head_src;

  // A response in the same cycle frees a tag slot, so a full FIFO can still accept.
  assign resp_valid   = mem_data_ok & (count_reg != '0);
  assign count_free   = (count_reg != FULL_COUNT) | mem_data_ok;
  assign can_accept   = (~hold_valid_reg | mem_addr_ok) & count_free;

  assign data_addr_ok = can_accept & data_req;
  assign inst_addr_ok = can_accept & inst_req & ~data_req;
  assign accept       = data_addr_ok | inst_addr_ok;

  assign head_src     = tag_mem_reg[rd_ptr_reg];
  assign inst_data_ok = resp_valid & ~head_src;
  assign data_data_ok = resp_valid & head_src;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_req   = hold_valid_reg;
  assign mem_wr    = hold_wr_reg;
  assign mem_size  = hold_size_reg;
  assign mem_wstrb = hold_wstrb_reg;
  assign mem_addr  = hold_addr_reg;
  assign mem_wdata = hold_wdata_reg;

  always_comb begin
    count_next = count_reg;
    case ({accept, resp_valid})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_valid_reg <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      if (accept) begin
        hold_valid_reg <= 1'b1;
      end else if (mem_addr_ok) begin
        hold_valid_reg <= 1'b0;
      end
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (resp_valid) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Payload fields need no reset: mem_req gates them.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_src_reg   <= data_req;
      hold_wr_reg    <= data_req ? data_wr    : inst_wr;
      hold_size_reg  <= data_req ? data_size  : inst_size;
      hold_wstrb_reg <= data_req ? data_wstrb : inst_wstrb;
      hold_addr_reg  <= data_req ? data_addr  : inst_addr;
      hold_wdata_reg <= data_req ? data_wdata : inst_wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (accept && (wr_ptr_reg == PTR_W'(gi))) begin
          tag_mem_reg[gi] <= data_req;
        end
      end
    end
  endgenerate

endmodule
